// File: rtl/eqed_sig_pkg.sv
// Shared types and constants for the E-QED signature checker.
// Optional serial unload is enabled by the EQED_SIG_UNLOAD_EN macro.
package eqed_sig_pkg;

  localparam int MISR_W_DEF = 6;
  localparam int IN_W_DEF   = 2;
  localparam int OUT_W_DEF  = 3;
  localparam int WINDOW_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_CHECK   = 2'd2
`ifdef EQED_SIG_UNLOAD_EN
    , ST_UNLOAD = 2'd3
`endif
  } state_e;

  // Seed has only the top stage set, e.g. 6'b100000 for a 6-stage MISR.
  function automatic logic [63:0] misr_seed(input int w);
    misr_seed = 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/eqed_sig_checker_if.sv
// Bus bundle between the E-QED wrapper (master) and the signature checker (slave).
// Serial unload pins are only active when EQED_SIG_UNLOAD_EN is defined.
interface eqed_sig_checker_if
  import eqed_sig_pkg::*;
#(
  parameter int MISR_W = MISR_W_DEF,
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
);
  // Handshake: start is a request sampled every clock; it is accepted only
  // when busy=0 (checker idle), and a run ends with a single-cycle done
  // strobe carrying pass, which then holds until the next accepted start.
  logic              start;
  logic [IN_W-1:0]   in_data;
  logic [OUT_W-1:0]  out_data;
  logic [MISR_W-1:0] golden_in;
  logic [MISR_W-1:0] golden_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [MISR_W-1:0] sig_in;
  logic [MISR_W-1:0] sig_out;
  logic              sig_sout;
  logic              sig_sout_vld;
  state_e            dbg_state;

  modport master (
    output start, in_data, out_data, golden_in, golden_out,
    input  busy, done, pass, sig_in, sig_out, sig_sout, sig_sout_vld, dbg_state
  );

  modport slave (
    input  start, in_data, out_data, golden_in, golden_out,
    output busy, done, pass, sig_in, sig_out, sig_sout, sig_sout_vld, dbg_state
  );

endinterface

// File: rtl/eqed_misr.sv
// Multiple-input signature register: seeded with only the top stage set,
// data bit j folds into even stage 2j (bit 0 into the feedback stage).
module eqed_misr
  import eqed_sig_pkg::*;
#(
  parameter int W   = MISR_W_DEF,
  parameter int D_W = IN_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           seed_load,
  input  logic           en,
  input  logic [D_W-1:0] d,
  output logic [W-1:0]   sig
);

  localparam int            PAD_W = (W + 1) / 2;
  localparam logic [W-1:0]  SEED  = W'(misr_seed(W));

  logic [W-1:0]     sig_q, sig_d;
  logic [W-1:0]     upd;
  logic [PAD_W-1:0] d_pad;

  always_comb begin
    d_pad  = PAD_W'(d);
    upd    = '0;
    upd[0] = sig_q[W-2] ^ sig_q[W-1] ^ d_pad[0];
    for (int k = 1; k < W; k++) begin
      upd[k] = sig_q[k-1];
      if (k % 2 == 0) upd[k] = upd[k] ^ d_pad[k/2];
    end
    sig_d = sig_q;
    if (seed_load) sig_d = SEED;
    else if (en)   sig_d = upd;
  end

  always_ff @(posedge clk) begin
    if (rst) sig_q <= SEED;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/eqed_sig_checker.sv
// E-QED signature checker: seeds two MISRs on start, compresses WINDOW cycles
// of stimulus/response, then reports pass/fail. Optional unload: EQED_SIG_UNLOAD_EN.
module eqed_sig_checker
  import eqed_sig_pkg::*;
#(
  parameter int MISR_W = MISR_W_DEF,
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input logic               clk,
  input logic               rst,
  eqed_sig_checker_if.slave bus
);

  localparam int               CNT_W    = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MISR_W-1:0] gold_in_q, gold_in_d;
  logic [MISR_W-1:0] gold_out_q, gold_out_d;
  logic              pass_q, pass_d;
  logic              done_q, done_d;
  logic              seed_load;
  logic              misr_en;
  logic [MISR_W-1:0] sig_in_w, sig_out_w;

`ifdef EQED_SIG_UNLOAD_EN
  localparam int              UL_W    = $clog2(2 * MISR_W);
  localparam logic [UL_W-1:0] UL_LAST = UL_W'(2 * MISR_W - 1);

  logic [UL_W-1:0]     ul_idx_q, ul_idx_d;
  logic [2*MISR_W-1:0] ul_vec;
`endif

  eqed_misr #(.W(MISR_W), .D_W(IN_W)) u_misr_in (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .en        (misr_en),
    .d         (bus.in_data),
    .sig       (sig_in_w)
  );

  eqed_misr #(.W(MISR_W), .D_W(OUT_W)) u_misr_out (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .en        (misr_en),
    .d         (bus.out_data),
    .sig       (sig_out_w)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gold_in_d  = gold_in_q;
    gold_out_d = gold_out_q;
    pass_d     = pass_q;
    done_d     = 1'b0;
    seed_load  = 1'b0;
    misr_en    = 1'b0;
`ifdef EQED_SIG_UNLOAD_EN
    ul_idx_d   = ul_idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          seed_load  = 1'b1;
          gold_in_d  = bus.golden_in;
          gold_out_d = bus.golden_out;
          cnt_d      = '0;
          pass_d     = 1'b0;
          state_d    = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        misr_en = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        pass_d = (sig_in_w == gold_in_q) && (sig_out_w == gold_out_q);
        done_d = 1'b1;
`ifdef EQED_SIG_UNLOAD_EN
        ul_idx_d = '0;
        state_d  = ST_UNLOAD;
`else
        state_d  = ST_IDLE;
`endif
      end
`ifdef EQED_SIG_UNLOAD_EN
      ST_UNLOAD: begin
        ul_idx_d = ul_idx_q + 1'b1;
        if (ul_idx_q == UL_LAST) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      gold_in_q  <= '0;
      gold_out_q <= '0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef EQED_SIG_UNLOAD_EN
      ul_idx_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gold_in_q  <= gold_in_d;
      gold_out_q <= gold_out_d;
      pass_q     <= pass_d;
      done_q     <= done_d;
`ifdef EQED_SIG_UNLOAD_EN
      ul_idx_q   <= ul_idx_d;
`endif
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.sig_in    = sig_in_w;
  assign bus.sig_out   = sig_out_w;
  assign bus.dbg_state = state_q;

`ifdef EQED_SIG_UNLOAD_EN
  // Input signature streams first, stage 0 first, then the output signature.
  assign ul_vec           = {sig_out_w, sig_in_w};
  assign bus.sig_sout_vld = (state_q == ST_UNLOAD);
  assign bus.sig_sout     = (state_q == ST_UNLOAD) & ul_vec[ul_idx_q];
`else
  assign bus.sig_sout_vld = 1'b0;
  assign bus.sig_sout     = 1'b0;
`endif

endmodule

// File: tb/tb_eqed_sig_checker.sv
// Directed bench for eqed_sig_checker: table of hand-computed signature runs
// plus multi-cycle sequences for held start, mid-run reset and serial unload.
module tb_eqed_sig_checker;
  import eqed_sig_pkg::*;

  localparam int MW  = 6;
  localparam int IW  = 2;
  localparam int OW  = 3;
  localparam int WIN = 5;
  localparam logic [MW-1:0] SEED = 6'b100000;

  typedef struct {
    string                   name;
    logic [WIN-1:0][IW-1:0]  din;
    logic [WIN-1:0][OW-1:0]  dout;
    logic [MW-1:0]           gin;
    logic [MW-1:0]           gout;
    logic [MW-1:0]           exp_si;
    logic [MW-1:0]           exp_so;
    logic                    exp_pass;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[6];

  eqed_sig_checker_if #(.MISR_W(MW), .IN_W(IW), .OUT_W(OW)) bus ();

  eqed_sig_checker #(.MISR_W(MW), .IN_W(IW), .OUT_W(OW), .WINDOW(WIN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: act=%0h req=%0h", nm, act, req);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({nm, "_idle_timeout"}, 32'(bus.busy), 32'd0);
  endtask

  // driver: one full run; start is asserted in the current cycle T
  task automatic run_vec(input vec_t v);
    bus.start      = 1'b1;
    bus.golden_in  = v.gin;
    bus.golden_out = v.gout;
    bus.in_data    = '0;
    bus.out_data   = '0;
    tick();                                   // T+1
    bus.start      = 1'b0;
    bus.golden_in  = ~v.gin;                  // goldens must already be latched
    bus.golden_out = ~v.gout;
    chk({v.name, "_busy_t1"}, 32'(bus.busy), 32'd1);
    chk({v.name, "_seed_in"}, 32'(bus.sig_in), 32'(SEED));
    chk({v.name, "_seed_out"}, 32'(bus.sig_out), 32'(SEED));
    for (int i = 0; i < WIN; i++) begin
      bus.in_data  = v.din[i];
      bus.out_data = v.dout[i];
      tick();
    end
    bus.in_data  = '0;                        // T+6: CHECK cycle
    bus.out_data = '0;
    chk({v.name, "_sig_in"}, 32'(bus.sig_in), 32'(v.exp_si));
    chk({v.name, "_sig_out"}, 32'(bus.sig_out), 32'(v.exp_so));
    chk({v.name, "_done_early"}, 32'(bus.done), 32'd0);
    tick();                                   // T+7
    chk({v.name, "_done"}, 32'(bus.done), 32'd1);
    chk({v.name, "_pass"}, 32'(bus.pass), 32'(v.exp_pass));
`ifndef EQED_SIG_UNLOAD_EN
    chk({v.name, "_busy_drop"}, 32'(bus.busy), 32'd0);
`endif
    tick();
    chk({v.name, "_done_strobe"}, 32'(bus.done), 32'd0);
    chk({v.name, "_pass_hold"}, 32'(bus.pass), 32'(v.exp_pass));
    wait_idle(v.name);
  endtask

  initial begin
    int            done_cnt;
    int            done_at;
    logic [11:0]   ul_exp;

    vecs[0] = '{name: "zero",      din: '0, dout: '0, gin: 6'b010000, gout: 6'b010000,
                exp_si: 6'b010000, exp_so: 6'b010000, exp_pass: 1'b1};
    vecs[1] = '{name: "bad_gout",  din: '0, dout: '0, gin: 6'b010000, gout: 6'b000000,
                exp_si: 6'b010000, exp_so: 6'b010000, exp_pass: 1'b0};
    vecs[2] = '{name: "in01_first", din: '0, dout: '0, gin: 6'b000000, gout: 6'b010000,
                exp_si: 6'b000000, exp_so: 6'b010000, exp_pass: 1'b1};
    vecs[2].din[0] = 2'b01;
    vecs[3] = '{name: "all_ones",  din: '1, dout: '1, gin: 6'b110001, gout: 6'b001001,
                exp_si: 6'b110001, exp_so: 6'b001001, exp_pass: 1'b1};
    vecs[4] = '{name: "out100_first", din: '0, dout: '0, gin: 6'b010000, gout: 6'b011101,
                exp_si: 6'b010000, exp_so: 6'b011100, exp_pass: 1'b0};
    vecs[4].dout[0] = 3'b100;
    vecs[5] = '{name: "in10_first", din: '0, dout: '0, gin: 6'b010011, gout: 6'b010000,
                exp_si: 6'b010011, exp_so: 6'b010000, exp_pass: 1'b1};
    vecs[5].din[0] = 2'b10;

    bus.start      = 1'b0;
    bus.in_data    = '0;
    bus.out_data   = '0;
    bus.golden_in  = '0;
    bus.golden_out = '0;
    rst            = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_pass", 32'(bus.pass), 32'd0);
    chk("rst_sout", 32'(bus.sig_sout), 32'd0);
    chk("rst_sout_vld", 32'(bus.sig_sout_vld), 32'd0);
    chk("rst_sig_in", 32'(bus.sig_in), 32'(SEED));
    chk("rst_sig_out", 32'(bus.sig_out), 32'(SEED));
    chk("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // start held for ten cycles: one verdict at T+7, retrigger only once idle
    bus.start      = 1'b1;
    bus.golden_in  = 6'b010000;
    bus.golden_out = 6'b010000;
    done_cnt = 0;
    done_at  = -1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c == 8) chk("held_busy_t8", 32'(bus.busy), 32'd1);
    end
    bus.start = 1'b0;
    chk("held_done_count", 32'(done_cnt), 32'd1);
    chk("held_done_cycle", 32'(done_at), 32'd7);
    wait_idle("held");
    tick();

    // reset at T+3 aborts without a verdict
    bus.start = 1'b1;
    tick();                                   // T+1
    bus.start = 1'b0;
    tick();                                   // T+2
    tick();                                   // T+3
    rst = 1'b1;
    tick();                                   // T+4
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_sig_in", 32'(bus.sig_in), 32'(SEED));
    chk("abort_sig_out", 32'(bus.sig_out), 32'(SEED));
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.done === 1'b1) done_cnt++;
      tick();
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    run_vec(vecs[0]);

`ifdef EQED_SIG_UNLOAD_EN
    // serial unload of the zero-data signatures
    ul_exp = 12'h410;
    bus.start      = 1'b1;
    bus.golden_in  = 6'b010000;
    bus.golden_out = 6'b010000;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();                        // T+7
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("ul_vld_%0d", i), 32'(bus.sig_sout_vld), 32'd1);
      chk($sformatf("ul_bit_%0d", i), 32'(bus.sig_sout), 32'(ul_exp[i]));
      chk($sformatf("ul_busy_%0d", i), 32'(bus.busy), 32'd1);
      tick();
    end
    chk("ul_busy_end", 32'(bus.busy), 32'd0);
    chk("ul_vld_end", 32'(bus.sig_sout_vld), 32'd0);
    chk("ul_sig_hold", 32'(bus.sig_in), 32'(6'b010000));
`else
    ul_exp = '0;
    chk("no_ul_vld", 32'(bus.sig_sout_vld | ul_exp[0]), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
